// File: rtl/mips_control_fsm.sv
// rtl/mips_control_fsm.sv - multicycle MIPS control FSM (optional addi support via MIPS_FSM_ADDI_EN)
module mips_control_fsm #(
    parameter int STATE_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [5:0]            opcode,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  mem_to_reg,
    output logic                  reg_dst,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            alu_op,
    output logic [1:0]            pc_source,
    output logic                  illegal_op,
    output logic [STATE_BITS-1:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        BEQ_EX   = 4'd8,
        JUMP_EX  = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_FSM_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t state;
    state_t next_state;

    // The branch is resolved by the datapath (pc_write_cond AND zero), so zero is unused here.
    logic unused_zero;
    assign unused_zero = zero;

    assign state_dbg = STATE_BITS'(state);

    // State register with synchronous active-low reset back to FETCH.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore output decode; ir_write/pc_write/illegal_op also look at inputs.
    always_comb begin
        next_state    = FETCH;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                next_state = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = RTYPE_EX;
                    OP_BEQ:       next_state = BEQ_EX;
                    OP_J:         next_state = JUMP_EX;
`ifdef MIPS_FSM_ADDI_EN
                    OP_ADDI:      next_state = ADDI_EX;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        next_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read   = 1'b1;
                iord       = 1'b1;
                next_state = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                next_state = mem_ready ? FETCH : MEMWR;
            end
            RTYPE_EX: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                next_state = RTYPE_WB;
            end
            RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = FETCH;
            end
            BEQ_EX: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                next_state    = FETCH;
            end
            JUMP_EX: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                next_state = FETCH;
            end
`ifdef MIPS_FSM_ADDI_EN
            ADDI_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
`endif
            default: next_state = FETCH;
        endcase
    end

endmodule
